sequential_restoring_divider: RTL

//  Iterative unsigned restoring divider; the inverse of the MAC datapath's array-multiplier cell.

---
 rtl/divider_pkg.sv | 18 +
 rtl/restoring_div_step.sv | 31 +++
 rtl/sequential_restoring_divider.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
// SIGNED_DIV_EN selects two's-complement operands in the top.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  localparam int DIV_MAX_W = 64;
  localparam logic [DIV_MAX_W-1:0] DIV_MAX_ONES = '1;

  function automatic int div_cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One shift / trial-subtract / restore iteration of the divider.
// Purely combinational; the top registers R and Q between steps.
module restoring_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH+1:0] rs;
  logic [WIDTH+1:0] t;
  logic [WIDTH-1:0] qs;

  assign rs = {r_i, q_i[WIDTH-1]};
  assign qs = {q_i[WIDTH-2:0], 1'b0};
  assign t  = rs - {2'b00, d_i};

  // A clear top bit means the trial subtraction did not borrow.
  always_comb begin
    r_o = rs[WIDTH:0];
    q_o = qs;
    if (!t[WIDTH+1]) begin
      r_o = t[WIDTH:0];
      q_o = {qs[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/sequential_restoring_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// SIGNED_DIV_EN defined: operands and results are two's complement.
module sequential_restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             valid_out,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] fin_q, fin_r;
  logic             accept;

  assign accept = (state_q == IDLE) && start;

  restoring_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (step_r),
    .q_o (step_q)
  );

`ifdef SIGNED_DIV_EN
  logic sq_q, sq_d;
  logic sr_q, sr_d;

  // Magnitude of MIN is 2^(WIDTH-1) read as unsigned, so MIN/-1 wraps.
  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign fin_q = sq_q ? -step_q : step_q;
  assign fin_r = sr_q ? -step_r[WIDTH-1:0] : step_r[WIDTH-1:0];

  always_comb begin
    sq_d = sq_q;
    sr_d = sr_q;
    if (accept) begin
      sq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sr_d = dividend[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q <= 1'b0;
      sr_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
      sr_q <= sr_d;
    end
  end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign fin_q = step_q;
  assign fin_r = step_r[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = DIV_MAX_ONES[WIDTH-1:0];
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            r_d     = '0;
            q_d     = a_mag;
            d_d     = b_mag;
            cnt_d   = '0;
          end
        end
      end
      CALC: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          quo_d   = fin_q;
          rem_d   = fin_r;
          dbz_d   = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign valid_out   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
